rtc_write_sequencer: RTL and testbench

RTC_WRITE_SEQUENCER -- requirements
Module: rtc_write_sequencer

---
 rtl/rtc_write_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_rtc_write_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_write_sequencer.sv
// Drives an 8-bit multiplexed address/data RTC bus through a fixed list of
// address/data writes: either the clock/timer write list or the init list.
module rtc_write_sequencer #(
    parameter int unsigned TPH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Escribe,
    input  logic       Inicializador,
    input  logic       clk_timer,
    input  logic [7:0] segundo,
    input  logic [7:0] minuto,
    input  logic [7:0] hora,
    input  logic [7:0] Dir_segundo,
    input  logic [7:0] Dir_minuto,
    input  logic [7:0] Dir_hora,
    output logic       T_Esc,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A_D,
    output logic [7:0] AD_out,
    output logic       AD_oe
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] ADDR   = 3'd2;
    localparam logic [2:0] ALATCH = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] RECOV  = 3'd5;
    localparam logic [2:0] NEXT   = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    localparam logic [7:0] PHASE_LAST = 8'(TPH - 1);

    logic [2:0] state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [2:0] idx, idx_next;
    logic       init_mode, init_next;
    logic       ct;
    logic [7:0] seg_l, min_l, hora_l, dseg_l, dmin_l, dhora_l;

    logic [7:0] ent_addr, ent_data;
    logic       ent_cmd;
    logic       phase_done;

    assign phase_done = (cnt == 8'd0);

    always_comb begin
        ent_addr = 8'h00;
        ent_data = 8'h00;
        ent_cmd  = 1'b0;
        if (init_mode) begin
            case (idx[1:0])
                2'd0:    begin ent_addr = 8'h02; ent_data = 8'h10; end
                2'd1:    begin ent_addr = 8'h02; ent_data = 8'h00; end
                2'd2:    begin ent_addr = 8'h10; ent_data = 8'hD2; end
                default: begin ent_addr = 8'h00; ent_data = 8'h00; end
            endcase
        end else begin
            case (idx[1:0])
                2'd0:    begin ent_addr = dseg_l;  ent_data = seg_l;  end
                2'd1:    begin ent_addr = dmin_l;  ent_data = min_l;  end
                2'd2:    begin ent_addr = dhora_l; ent_data = hora_l; end
                default: begin ent_addr = ct ? 8'hF1 : 8'hF2; ent_cmd = 1'b1; end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        init_next  = init_mode;
        case (state)
            IDLE: begin
                idx_next = 3'd0;
                cnt_next = 8'd0;
                if (Inicializador) begin
                    init_next  = 1'b1;
                    state_next = LOAD;
                end else if (Escribe) begin
                    init_next  = 1'b0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = ADDR;
                cnt_next   = PHASE_LAST;
            end
            ADDR, ALATCH, DATA, RECOV: begin
                if (!phase_done) begin
                    cnt_next = cnt - 8'd1;
                end else begin
                    cnt_next = PHASE_LAST;
                    case (state)
                        ADDR:    state_next = ALATCH;
                        // Command entries carry no data byte.
                        ALATCH:  state_next = ent_cmd ? RECOV : DATA;
                        DATA:    state_next = RECOV;
                        default: begin
                            state_next = NEXT;
                            cnt_next   = 8'd0;
                        end
                    endcase
                end
            end
            NEXT: begin
                idx_next = idx + 3'd1;
                if (idx == 3'd3) begin
                    state_next = DONE;
                end else begin
                    state_next = ADDR;
                    cnt_next   = PHASE_LAST;
                end
            end
            default: begin
                if (!Escribe && !Inicializador) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            idx       <= 3'd0;
            init_mode <= 1'b0;
            ct        <= 1'b0;
            seg_l     <= 8'd0;
            min_l     <= 8'd0;
            hora_l    <= 8'd0;
            dseg_l    <= 8'd0;
            dmin_l    <= 8'd0;
            dhora_l   <= 8'd0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            init_mode <= init_next;
            if (state == LOAD) begin
                ct      <= clk_timer;
                seg_l   <= segundo;
                min_l   <= minuto;
                hora_l  <= hora;
                dseg_l  <= Dir_segundo;
                dmin_l  <= Dir_minuto;
                dhora_l <= Dir_hora;
            end
        end
    end

    // Bus pins decode straight from state so reset idles them without a clock.
    always_comb begin
        T_Esc  = 1'b0;
        CS_n   = 1'b1;
        RD_n   = 1'b1;
        WR_n   = 1'b1;
        A_D    = 1'b0;
        AD_out = 8'h00;
        AD_oe  = 1'b0;
        case (state)
            ADDR: begin
                CS_n   = 1'b0;
                WR_n   = 1'b0;
                AD_out = ent_addr;
                AD_oe  = 1'b1;
            end
            ALATCH: begin
                AD_out = ent_addr;
                AD_oe  = 1'b1;
            end
            DATA: begin
                CS_n   = 1'b0;
                WR_n   = 1'b0;
                A_D    = 1'b1;
                AD_out = ent_data;
                AD_oe  = 1'b1;
            end
            RECOV:   A_D   = 1'b1;
            DONE:    T_Esc = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Directed bench: write lists, init list, mid-sequence reset, input latching,
// and a TPH=1 instance with a single-cycle request.
module tb_rtc_write_sequencer;

    logic       clk;
    logic       reset;
    logic       Escribe, Inicializador, Escribe1, Inicializador1;
    logic       clk_timer;
    logic [7:0] segundo, minuto, hora, Dir_segundo, Dir_minuto, Dir_hora;

    logic       T_Esc, CS_n, RD_n, WR_n, A_D, AD_oe;
    logic [7:0] AD_out;
    logic       T_Esc1, CS_n1, RD_n1, WR_n1, A_D1, AD_oe1;
    logic [7:0] AD_out1;

    int checks = 0;
    int errors = 0;

    rtc_write_sequencer #(.TPH(4)) dut (
        .clk(clk), .reset(reset), .Escribe(Escribe), .Inicializador(Inicializador),
        .clk_timer(clk_timer), .segundo(segundo), .minuto(minuto), .hora(hora),
        .Dir_segundo(Dir_segundo), .Dir_minuto(Dir_minuto), .Dir_hora(Dir_hora),
        .T_Esc(T_Esc), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A_D(A_D),
        .AD_out(AD_out), .AD_oe(AD_oe)
    );

    rtc_write_sequencer #(.TPH(1)) dut1 (
        .clk(clk), .reset(reset), .Escribe(Escribe1), .Inicializador(Inicializador1),
        .clk_timer(clk_timer), .segundo(segundo), .minuto(minuto), .hora(hora),
        .Dir_segundo(Dir_segundo), .Dir_minuto(Dir_minuto), .Dir_hora(Dir_hora),
        .T_Esc(T_Esc1), .CS_n(CS_n1), .RD_n(RD_n1), .WR_n(WR_n1), .A_D(A_D1),
        .AD_out(AD_out1), .AD_oe(AD_oe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: records {A_D, AD_out} at each WR_n falling edge and WR_n pulse widths.
    logic [8:0] cap [0:63];
    int         pw  [0:63];
    int         cap_n = 0;
    int         pw_n = 0;
    int         wr_len = 0;
    logic       wr_prev = 1'b1;
    logic       wr1_prev = 1'b1;
    int         rd_low = 0;
    int         t1_cnt = 0;
    int         s1_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            wr_prev  <= 1'b1;
            wr1_prev <= 1'b1;
            wr_len   <= 0;
        end else begin
            if (!WR_n && wr_prev && cap_n < 64) begin
                cap[cap_n] <= {A_D, AD_out};
                cap_n      <= cap_n + 1;
            end
            if (!WR_n) begin
                wr_len <= wr_len + 1;
            end else if (wr_len != 0) begin
                if (pw_n < 64) begin
                    pw[pw_n] <= wr_len;
                    pw_n     <= pw_n + 1;
                end
                wr_len <= 0;
            end
            wr_prev <= WR_n;
            if (!WR_n1 && wr1_prev) s1_cnt <= s1_cnt + 1;
            if (T_Esc1) t1_cnt <= t1_cnt + 1;
            wr1_prev <= WR_n1;
        end
        if (!RD_n || !RD_n1) rd_low <= rd_low + 1;
    end

    logic [8:0] exp_cap [0:7];
    int         exp_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_write_exp();
        exp_cap[0] = {1'b0, Dir_segundo};
        exp_cap[1] = {1'b1, segundo};
        exp_cap[2] = {1'b0, Dir_minuto};
        exp_cap[3] = {1'b1, minuto};
        exp_cap[4] = {1'b0, Dir_hora};
        exp_cap[5] = {1'b1, hora};
        exp_cap[6] = {1'b0, (clk_timer ? 8'hF1 : 8'hF2)};
        exp_n      = 7;
    endtask

    // Caller raises the request before the next rising edge (the start edge).
    task automatic run_seq(input int exp_lat, input bit glitch);
        int base, pbase, lat;
        base  = cap_n;
        pbase = pw_n;
        lat   = 0;
        @(posedge clk);
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (glitch && n == 1) segundo = 8'hAA;
            if (T_Esc) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, exp_lat);
        repeat (2) @(posedge clk);
        #1;
        check("tesc_hold", T_Esc, 1);
        @(negedge clk);
        Escribe       = 1'b0;
        Inicializador = 1'b0;
        @(posedge clk);
        #1;
        check("tesc_clear", T_Esc, 0);
        check("idle_cs", CS_n, 1);
        check("idle_oe", AD_oe, 0);
        check("cap_count", cap_n - base, exp_n);
        for (int i = 0; i < exp_n && base + i < 64; i++)
            check($sformatf("cap%0d", i), cap[base + i], exp_cap[i]);
        check("pulse_count", pw_n - pbase, exp_n);
        for (int i = pbase; i < pw_n && i < 64; i++)
            check($sformatf("pulse%0d", i - pbase), pw[i], 4);
    endtask

    initial begin
        int lat;
        reset = 1'b0; Escribe = 1'b0; Inicializador = 1'b0;
        Escribe1 = 1'b0; Inicializador1 = 1'b0;
        clk_timer = 1'b1;
        segundo = 8'h15; minuto = 8'h30; hora = 8'h08;
        Dir_segundo = 8'h21; Dir_minuto = 8'h22; Dir_hora = 8'h23;
        repeat (2) @(negedge clk);
        check("rst_tesc", T_Esc, 0);
        check("rst_cs", CS_n, 1);
        check("rst_rd", RD_n, 1);
        check("rst_wr", WR_n, 1);
        check("rst_ad", A_D, 0);
        check("rst_bus", AD_out, 0);
        check("rst_oe", AD_oe, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_req", CS_n, 1);

        // Write list, clock registers; segundo changes right after LOAD.
        set_write_exp();
        Escribe = 1'b1;
        run_seq(65, 1'b1);
        segundo = 8'h15;

        // Write list, timer registers.
        @(negedge clk);
        clk_timer = 1'b0;
        Dir_segundo = 8'h41; Dir_minuto = 8'h42; Dir_hora = 8'h43;
        set_write_exp();
        Escribe = 1'b1;
        run_seq(65, 1'b0);

        // Init has priority over write.
        @(negedge clk);
        exp_cap[0] = 9'h002; exp_cap[1] = 9'h110;
        exp_cap[2] = 9'h002; exp_cap[3] = 9'h100;
        exp_cap[4] = 9'h010; exp_cap[5] = 9'h1D2;
        exp_cap[6] = 9'h000; exp_cap[7] = 9'h100;
        exp_n = 8;
        Escribe = 1'b1;
        Inicializador = 1'b1;
        run_seq(69, 1'b0);

        // Reset during DATA of the 2nd entry, then restart with Escribe held.
        @(negedge clk);
        clk_timer = 1'b1;
        Dir_segundo = 8'h21; Dir_minuto = 8'h22; Dir_hora = 8'h23;
        set_write_exp();
        Escribe = 1'b1;
        @(posedge clk);
        repeat (27) @(posedge clk);
        #1;
        check("pre_rst_data", {A_D, WR_n, AD_out}, {2'b10, 8'h30});
        reset = 1'b0;
        #1;
        check("mid_rst_cs", CS_n, 1);
        check("mid_rst_wr", WR_n, 1);
        check("mid_rst_oe", AD_oe, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_seq(65, 1'b0);

        // TPH=1 instance, one-cycle request.
        @(negedge clk);
        Escribe1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Escribe1 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (T_Esc1) begin
                lat = n;
                break;
            end
        end
        check("tph1_latency", lat, 20);
        repeat (3) @(posedge clk);
        #1;
        check("tph1_tesc_low", T_Esc1, 0);
        check("tph1_tesc_cycles", t1_cnt, 1);
        check("tph1_strobes", s1_cnt, 7);
        check("rd_never_low", rd_low, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
